// File: rtl/param_bus_datapath_pkg.sv
// Shared encodings for the single-bus datapath: select offsets above the
// general registers, the memory engine state set and the select width.
package param_bus_datapath_pkg;

    localparam int SEL_W = 5;

    // Bus sources that follow R0..NREGS-1, as offsets from NREGS
    typedef enum logic [2:0] {
        SRC_HI     = 3'd0,
        SRC_LO     = 3'd1,
        SRC_ZHI    = 3'd2,
        SRC_ZLO    = 3'd3,
        SRC_PC     = 3'd4,
        SRC_MDR    = 3'd5,
        SRC_INPORT = 3'd6,
        SRC_C      = 3'd7
    } src_ofs_e;

    // Bus destinations that follow R0..NREGS-1, as offsets from NREGS
    typedef enum logic [2:0] {
        DST_HI      = 3'd0,
        DST_LO      = 3'd1,
        DST_PC      = 3'd2,
        DST_IR      = 3'd3,
        DST_MAR     = 3'd4,
        DST_MDR     = 3'd5,
        DST_Y       = 3'd6,
        DST_OUTPORT = 3'd7
    } dst_ofs_e;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_e;

endpackage

// File: rtl/param_bus_datapath_if.sv
// Memory-side handshake bundle: the datapath is the master, memory the slave.
interface param_bus_datapath_if #(
    parameter int WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/param_bus_datapath_mem_handshake_fsm.sv
// Memory read/write engine: one request cycle, then waits for ack with a
// bounded cycle budget. Reports completion as a one-cycle pulse and a
// timeout as a sticky error.
module mem_handshake_fsm
    import param_bus_datapath_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic write,
    input  logic ack,
    output logic req,
    output logic we,
    output logic busy,
    output logic done,
    output logic err,
    output logic rd_capture
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    mem_state_e       state;
    mem_state_e       state_next;
    logic [CNT_W-1:0] count;
    logic             count_clear;
    logic             count_inc;
    logic             done_set;
    logic             err_set;

    // State, wait counter, latched op type and the done/error flags
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= MEM_IDLE;
            count <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            we    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_set;
            if (err_set) begin
                err <= 1'b1;
            end
            if (count_clear) begin
                count <= '0;
            end else if (count_inc) begin
                count <= count + CNT_W'(1);
            end
            if (state == MEM_IDLE && start) begin
                we <= write;
            end
        end
    end

    // Next state and per-cycle strobes; an ack on the last wait cycle wins over timeout
    always_comb begin
        state_next  = state;
        count_clear = 1'b0;
        count_inc   = 1'b0;
        done_set    = 1'b0;
        err_set     = 1'b0;
        rd_capture  = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (start) begin
                    state_next = MEM_REQ;
                end
            end
            MEM_REQ: begin
                state_next  = MEM_WAIT;
                count_clear = 1'b1;
            end
            MEM_WAIT: begin
                if (ack) begin
                    rd_capture = !we;
                    done_set   = 1'b1;
                    state_next = MEM_IDLE;
                end else if (count == LAST_WAIT) begin
                    err_set    = 1'b1;
                    done_set   = 1'b1;
                    state_next = MEM_IDLE;
                end else begin
                    count_inc = 1'b1;
                end
            end
            default: state_next = MEM_IDLE;
        endcase
    end

    assign req  = (state != MEM_IDLE);
    assign busy = (state != MEM_IDLE);

endmodule

// File: rtl/param_bus_datapath.sv
// Single-bus CPU datapath: encoded source/destination selects onto one
// shared bus, general register file, HI/LO/PC/IR/MAR/MDR/Y/Z/OUTPORT, and a
// handshaked memory engine working from MAR/MDR. The ALU sits outside.
module param_bus_datapath
    import param_bus_datapath_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NREGS       = 16,
    parameter int C_W         = 19,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [SEL_W-1:0]     src_sel,
    input  logic                 dst_we,
    input  logic [SEL_W-1:0]     dst_sel,
    input  logic                 ba_out,
    input  logic                 inc_pc,
    input  logic                 z_we,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    input  logic [2*WIDTH-1:0]   alu_result,
    input  logic                 mem_start,
    input  logic                 mem_write,
    param_bus_datapath_if.master mem,
    output logic                 mem_busy,
    output logic                 mem_done,
    output logic                 mem_err,
    input  logic [WIDTH-1:0]     in_port,
    output logic [WIDTH-1:0]     out_port,
    output logic [WIDTH-1:0]     bus,
    output logic [WIDTH-1:0]     ir
);

    localparam int IDX_W = $clog2(NREGS);
    localparam logic [SEL_W-1:0] NREGS_SEL = SEL_W'(NREGS);

    logic [WIDTH-1:0]   gpr [NREGS];
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   pc;
    logic [WIDTH-1:0]   mar;
    logic [WIDTH-1:0]   mdr;
    logic [WIDTH-1:0]   y;
    logic [2*WIDTH-1:0] z;

    logic [SEL_W-1:0] src_diff;
    logic [SEL_W-1:0] dst_diff;
    logic [WIDTH-1:0] c_value;
    logic             dst_is_gpr;
    logic             dst_is_special;
    dst_ofs_e         dst_ofs;
    logic             wr_hi, wr_lo, wr_pc, wr_ir, wr_mar, wr_mdr, wr_y, wr_out;
    logic             rd_capture;
    logic             fsm_req;
    logic             fsm_we;

    assign src_diff = src_sel - NREGS_SEL;
    assign dst_diff = dst_sel - NREGS_SEL;
    assign c_value  = {{(WIDTH-C_W){ir[C_W-1]}}, ir[C_W-1:0]};

    // Bus multiplexer: exactly one source, R0 reads zero under ba_out, unknown selects read zero
    always_comb begin
        bus = '0;
        if (src_sel < NREGS_SEL) begin
            if (!(ba_out && src_sel == '0)) begin
                bus = gpr[src_sel[IDX_W-1:0]];
            end
        end else if (src_diff[SEL_W-1:3] == '0) begin
            case (src_ofs_e'(src_diff[2:0]))
                SRC_HI:     bus = hi;
                SRC_LO:     bus = lo;
                SRC_ZHI:    bus = z[2*WIDTH-1:WIDTH];
                SRC_ZLO:    bus = z[WIDTH-1:0];
                SRC_PC:     bus = pc;
                SRC_MDR:    bus = mdr;
                SRC_INPORT: bus = in_port;
                SRC_C:      bus = c_value;
                default:    bus = '0;
            endcase
        end
    end

    // Destination decode; MAR and MDR are frozen while a memory op is in flight
    assign dst_is_gpr     = dst_we && (dst_sel < NREGS_SEL);
    assign dst_is_special = dst_we && !(dst_sel < NREGS_SEL) && (dst_diff[SEL_W-1:3] == '0);
    assign dst_ofs        = dst_ofs_e'(dst_diff[2:0]);
    assign wr_hi  = dst_is_special && (dst_ofs == DST_HI);
    assign wr_lo  = dst_is_special && (dst_ofs == DST_LO);
    assign wr_pc  = dst_is_special && (dst_ofs == DST_PC);
    assign wr_ir  = dst_is_special && (dst_ofs == DST_IR);
    assign wr_mar = dst_is_special && (dst_ofs == DST_MAR) && !mem_busy;
    assign wr_mdr = dst_is_special && (dst_ofs == DST_MDR) && !mem_busy;
    assign wr_y   = dst_is_special && (dst_ofs == DST_Y);
    assign wr_out = dst_is_special && (dst_ofs == DST_OUTPORT);

    // General register file write port
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (dst_is_gpr) begin
            gpr[dst_sel[IDX_W-1:0]] <= bus;
        end
    end

    // Special registers; a bus write to PC takes precedence over increment
    always_ff @(posedge clk) begin
        if (clr) begin
            hi       <= '0;
            lo       <= '0;
            pc       <= '0;
            ir       <= '0;
            mar      <= '0;
            mdr      <= '0;
            y        <= '0;
            out_port <= '0;
        end else begin
            if (wr_hi)  hi       <= bus;
            if (wr_lo)  lo       <= bus;
            if (wr_ir)  ir       <= bus;
            if (wr_mar) mar      <= bus;
            if (wr_y)   y        <= bus;
            if (wr_out) out_port <= bus;
            if (wr_pc) begin
                pc <= bus;
            end else if (inc_pc) begin
                pc <= pc + WIDTH'(1);
            end
            if (rd_capture) begin
                mdr <= mem.mem_rdata;
            end else if (wr_mdr) begin
                mdr <= bus;
            end
        end
    end

    // Z captures the full double-width ALU result independently of the bus
    always_ff @(posedge clk) begin
        if (clr) begin
            z <= '0;
        end else if (z_we) begin
            z <= alu_result;
        end
    end

    mem_handshake_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_fsm (
        .clk        (clk),
        .clr        (clr),
        .start      (mem_start),
        .write      (mem_write),
        .ack        (mem.mem_ack),
        .req        (fsm_req),
        .we         (fsm_we),
        .busy       (mem_busy),
        .done       (mem_done),
        .err        (mem_err),
        .rd_capture (rd_capture)
    );

    assign mem.mem_req   = fsm_req;
    assign mem.mem_we    = fsm_we;
    assign mem.mem_addr  = mar;
    assign mem.mem_wdata = mdr;
    assign alu_a         = y;
    assign alu_b         = bus;

endmodule
